// File: rtl/qsys_data_arb_pkg.sv
// Shared constants and types for the qsys data-RAM arbiter.
// Build option: QSYS_DATA_ARB_FIXED_PRIO_EN selects fixed priority (m0 wins ties).
package qsys_data_arb_pkg;

   localparam int ADDR_W       = 10;
   localparam int DATA_W       = 32;
   localparam int BE_W         = DATA_W / 8;
   localparam int READ_LATENCY = 2;

   typedef logic req_id_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
      logic              write;
   } arb_cmd_t;

   // One stage of the read-return pipeline: which requester owns the data.
   typedef struct packed {
      logic    valid;
      req_id_t id;
   } ret_stage_t;

   function automatic arb_cmd_t make_cmd(input logic [ADDR_W-1:0] addr,
                                         input logic [BE_W-1:0]   be,
                                         input logic [DATA_W-1:0] wdata,
                                         input logic              write);
      arb_cmd_t c;
      c.addr  = addr;
      c.be    = be;
      c.wdata = wdata;
      c.write = write;
      return c;
   endfunction

endpackage

// File: rtl/qsys_data_arb_rr.sv
// Two-way grant logic. Default: round-robin on ties using last_grant.
// With QSYS_DATA_ARB_FIXED_PRIO_EN defined, m0 always wins ties and no history is kept.
module qsys_data_arb_rr
   import qsys_data_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] active,
   output logic [1:0] grant
);

`ifdef QSYS_DATA_ARB_FIXED_PRIO_EN

   logic unused_ok;
   assign unused_ok = ^{clk, 1'b0};

   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         case (active)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

`else

   // 1 means m1 was granted most recently, so m0 takes the next tie.
   req_id_t last_grant;

   always_comb begin
      grant = 2'b00;
      if (!reset) begin
         case (active)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (|grant) begin
         last_grant <= grant[1];
      end
   end

`endif

endmodule

// File: rtl/qsys_data_arbiter.sv
// Shares the single-port 1024x32 data RAM between two Avalon-MM masters.
// Build option: QSYS_DATA_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module qsys_data_arbiter
   import qsys_data_arb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata
);

   // Handshake: a command is accepted in the cycle where (read|write) is high
   // and waitrequest is low; write wins when both are set. Read data returns
   // READ_LATENCY cycles later, qualified by a one-cycle readdatavalid.

   logic [1:0]  active;
   logic [1:0]  grant;
   logic        granted;
   arb_cmd_t    sel_cmd;
   arb_cmd_t    cmd_q;
   logic        cs_q;
   ret_stage_t [READ_LATENCY-1:0] ret_pipe;
   ret_stage_t  ret_out;

   assign active  = {m1_read | m1_write, m0_read | m0_write};
   assign granted = |grant;

   qsys_data_arb_rr u_rr (
      .clk    (clk),
      .reset  (reset),
      .active (active),
      .grant  (grant)
   );

   assign m0_waitrequest = reset | (active[0] & ~grant[0]);
   assign m1_waitrequest = reset | (active[1] & ~grant[1]);

   always_comb begin
      sel_cmd = make_cmd(m0_address, m0_byteenable, m0_writedata, m0_write);
      if (grant[1]) begin
         sel_cmd = make_cmd(m1_address, m1_byteenable, m1_writedata, m1_write);
      end
   end

   // Command register; ram_write is cleared on idle cycles so it never
   // lingers without chipselect.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q <= '0;
         cs_q  <= 1'b0;
      end else begin
         cs_q <= granted;
         if (granted) begin
            cmd_q <= sel_cmd;
         end else begin
            cmd_q.write <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ret_pipe <= '0;
      end else begin
         ret_pipe[0].valid <= granted & ~sel_cmd.write;
         ret_pipe[0].id    <= grant[1];
         for (int i = 1; i < READ_LATENCY; i++) begin
            ret_pipe[i] <= ret_pipe[i-1];
         end
      end
   end

   assign ret_out = ret_pipe[READ_LATENCY-1];

   assign m0_readdatavalid = ret_out.valid & (ret_out.id == 1'b0);
   assign m1_readdatavalid = ret_out.valid & (ret_out.id == 1'b1);
   assign m0_readdata      = ram_readdata;
   assign m1_readdata      = ram_readdata;

   assign ram_address    = cmd_q.addr;
   assign ram_byteenable = cmd_q.be;
   assign ram_writedata  = cmd_q.wdata;
   assign ram_write      = cmd_q.write;
   assign ram_chipselect = cs_q;
   assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_qsys_data_arbiter.sv
// Bench for qsys_data_arbiter: RAM model, directed vector table, then random
// traffic checked against a transaction-level reference model.
module tb_qsys_data_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int BW = 4;
   localparam logic [1:0] OP_IDLE = 2'd0;
   localparam logic [1:0] OP_RD   = 2'd1;
   localparam logic [1:0] OP_WR   = 2'd2;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] m0_address, m1_address;
   logic [BW-1:0] m0_byteenable, m1_byteenable;
   logic          m0_read, m0_write, m1_read, m1_write;
   logic [DW-1:0] m0_writedata, m1_writedata;
   logic          m0_waitrequest, m1_waitrequest;
   logic [DW-1:0] m0_readdata, m1_readdata;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic [AW-1:0] ram_address;
   logic [BW-1:0] ram_byteenable;
   logic          ram_chipselect, ram_write, ram_clken;
   logic [DW-1:0] ram_writedata;
   logic [DW-1:0] ram_readdata;

   // ---------------- clock / reset block
   always #5 clk = ~clk;

   qsys_data_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
      .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
      .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .ram_address(ram_address), .ram_byteenable(ram_byteenable),
      .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
   );

   // ---------------- single-port RAM with one-cycle registered read
   logic          ram_init;
   logic [DW-1:0] ram_mem [0:(1<<AW)-1];

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= '0;
         ram_mem[10'h010] <= 32'h1111_1111;
         ram_mem[10'h020] <= 32'h2222_2222;
         ram_mem[10'h100] <= 32'hCAFE_0000;
      end else if (ram_clken && ram_chipselect) begin
         if (ram_write) begin
            for (int b = 0; b < BW; b++)
               if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= ram_mem[ram_address];
         end
      end
   end

   // ---------------- vector records
   typedef struct {
      bit            chk;
      bit            rst;
      bit            rd0, wr0, rd1, wr1;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic [BW-1:0] be0, be1;
      logic [1:0]    ew;    // {m1_waitrequest, m0_waitrequest}
      logic [1:0]    erv;   // {m1_readdatavalid, m0_readdatavalid}
      logic [DW-1:0] edata;
   } vec_t;

   function automatic vec_t mk(input bit rst,
                               input logic [1:0] op0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic [BW-1:0] be0,
                               input logic [1:0] op1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1, input logic [BW-1:0] be1,
                               input logic [1:0] ew, input logic [1:0] erv,
                               input logic [DW-1:0] edata);
      vec_t v;
      v.chk = 1'b1; v.rst = rst;
      v.rd0 = (op0 == OP_RD); v.wr0 = (op0 == OP_WR);
      v.rd1 = (op1 == OP_RD); v.wr1 = (op1 == OP_WR);
      v.a0 = a0; v.d0 = d0; v.be0 = be0;
      v.a1 = a1; v.d1 = d1; v.be1 = be1;
      v.ew = ew; v.erv = erv; v.edata = edata;
      return v;
   endfunction

   // ---------------- reference model and scoreboard
   typedef struct {
      int            due;
      bit            id;
      logic [DW-1:0] data;
   } ret_t;

   ret_t          exp_q[$];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   bit            model_last;
   bit            prev_gv, prev_gw;
   logic [AW-1:0] prev_ga;
   logic [DW-1:0] prev_gd;
   logic [BW-1:0] prev_gbe;
   int            cyc;
   int            n_vec;
   int            n_err;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // ---------------- driver: apply one cycle, compare, advance the model
   task automatic run_cycle(input vec_t v);
      bit            act0, act1, g0, g1, gid, gw, erv0, erv1;
      logic [DW-1:0] edata;
      logic [AW-1:0] ga;
      logic [DW-1:0] gd;
      logic [BW-1:0] gbe;
      ret_t          r;

      reset = v.rst;
      m0_read = v.rd0; m0_write = v.wr0; m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.be0;
      m1_read = v.rd1; m1_write = v.wr1; m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.be1;
      @(negedge clk);

      act0 = v.rd0 | v.wr0;
      act1 = v.rd1 | v.wr1;
      g0 = 1'b0; g1 = 1'b0;
      if (!v.rst) begin
         if (act0 && act1) begin
`ifdef QSYS_DATA_ARB_FIXED_PRIO_EN
            g0 = 1'b1;
`else
            if (model_last) g0 = 1'b1;
            else            g1 = 1'b1;
`endif
         end else begin
            g0 = act0;
            g1 = act1;
         end
      end

      erv0 = 1'b0; erv1 = 1'b0; edata = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         r = exp_q.pop_front();
         if (r.id) erv1 = 1'b1;
         else      erv0 = 1'b1;
         edata = r.data;
      end

      check("m0_waitrequest", m0_waitrequest, v.rst | (act0 & ~g0));
      check("m1_waitrequest", m1_waitrequest, v.rst | (act1 & ~g1));
      check("ram_chipselect", ram_chipselect, prev_gv);
      check("ram_write", ram_write, prev_gv & prev_gw);
      check("ram_clken", ram_clken, 1'b1);
      if (prev_gv) begin
         check("ram_address", ram_address, prev_ga);
         if (prev_gw) begin
            check("ram_writedata", ram_writedata, prev_gd);
            check("ram_byteenable", ram_byteenable, prev_gbe);
         end
      end
      check("m0_readdatavalid", m0_readdatavalid, erv0);
      check("m1_readdatavalid", m1_readdatavalid, erv1);
      if (erv0) check("m0_readdata", m0_readdata, edata);
      if (erv1) check("m1_readdata", m1_readdata, edata);

      if (v.chk) begin
         check("tbl_waitrequest", {m1_waitrequest, m0_waitrequest}, v.ew);
         check("tbl_readdatavalid", {m1_readdatavalid, m0_readdatavalid}, v.erv);
         if (v.erv[0]) check("tbl_m0_readdata", m0_readdata, v.edata);
         if (v.erv[1]) check("tbl_m1_readdata", m1_readdata, v.edata);
      end

      prev_gv = g0 | g1;
      prev_gw = 1'b0;
      if (g0 | g1) begin
         gid = g1;
         ga  = gid ? v.a1  : v.a0;
         gd  = gid ? v.d1  : v.d0;
         gbe = gid ? v.be1 : v.be0;
         gw  = gid ? v.wr1 : v.wr0;
         prev_ga = ga; prev_gd = gd; prev_gbe = gbe; prev_gw = gw;
         if (gw) begin
            for (int b = 0; b < BW; b++)
               if (gbe[b]) ref_mem[ga][8*b +: 8] = gd[8*b +: 8];
         end else begin
            exp_q.push_back('{due: cyc + 2, id: gid, data: ref_mem[ga]});
         end
         model_last = gid;
      end
      if (v.rst) begin
         exp_q.delete();
         model_last = 1'b1;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus
   vec_t tbl [0:32];
   vec_t rv;

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      model_last = 1'b1; prev_gv = 1'b0; prev_gw = 1'b0;
      prev_ga = '0; prev_gd = '0; prev_gbe = '0;
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
      ref_mem[10'h010] = 32'h1111_1111;
      ref_mem[10'h020] = 32'h2222_2222;
      ref_mem[10'h100] = 32'hCAFE_0000;

      ram_init = 1'b1;
      reset = 1'b1;
      m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
      m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
      repeat (2) @(posedge clk);
      #1;
      ram_init = 1'b0;

      //            rst op0    a0      d0            be0   op1      a1      d1            be1   ew     erv    edata
      tbl[0]  = mk(1, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b11, 2'b00, 0);
      tbl[1]  = mk(0, OP_WR,   10'h005, 32'hDEADBEEF, 4'hF, OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[2]  = mk(0, OP_RD,   10'h005, 0,            4'hF, OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[3]  = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[4]  = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b01, 32'hDEADBEEF);
      tbl[5]  = mk(0, OP_IDLE, 0,       0,            0,    OP_RD,   10'h030, 0,            4'hF, 2'b00, 2'b00, 0);
      tbl[6]  = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b10, 2'b00, 0);
      tbl[7]  = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b01, 2'b10, 0);
      tbl[8]  = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b10, 2'b01, 32'h11111111);
      tbl[9]  = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b01, 2'b10, 32'h22222222);
      tbl[10] = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b10, 2'b01, 32'h11111111);
      tbl[11] = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b01, 2'b10, 32'h22222222);
      tbl[12] = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b10, 2'b01, 32'h11111111);
      tbl[13] = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b01, 2'b10, 32'h22222222);
      tbl[14] = mk(0, OP_IDLE, 0,       0,            0,    OP_WR,   10'h030, 32'hAABBCCDD, 4'h3, 2'b00, 2'b01, 32'h11111111);
      tbl[15] = mk(0, OP_IDLE, 0,       0,            0,    OP_RD,   10'h030, 0,            4'hF, 2'b00, 2'b10, 32'h22222222);
      tbl[16] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[17] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b10, 32'h0000CCDD);
      tbl[18] = mk(0, OP_RD,   10'h100, 0,            4'hF, OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[19] = mk(0, OP_WR,   10'h100, 32'h12345678, 4'hF, OP_RD,   10'h100, 0,            4'hF, 2'b01, 2'b00, 0);
      tbl[20] = mk(0, OP_WR,   10'h100, 32'h12345678, 4'hF, OP_IDLE, 0,       0,            0,    2'b00, 2'b01, 32'hCAFE0000);
      tbl[21] = mk(0, OP_RD,   10'h100, 0,            4'hF, OP_IDLE, 0,       0,            0,    2'b00, 2'b10, 32'hCAFE0000);
      tbl[22] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[23] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b01, 32'h12345678);
      tbl[24] = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[25] = mk(1, OP_IDLE, 0,       0,            0,    OP_RD,   10'h020, 0,            4'hF, 2'b11, 2'b00, 0);
      tbl[26] = mk(1, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b11, 2'b00, 0);
      tbl[27] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[28] = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b10, 2'b00, 0);
      tbl[29] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[30] = mk(0, OP_RD,   10'h010, 0,            4'hF, OP_RD,   10'h020, 0,            4'hF, 2'b01, 2'b01, 32'h11111111);
      tbl[31] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b00, 0);
      tbl[32] = mk(0, OP_IDLE, 0,       0,            0,    OP_IDLE, 0,       0,            0,    2'b00, 2'b10, 32'h22222222);

      for (int i = 0; i <= 32; i++) run_cycle(tbl[i]);

      // Random traffic over a small address window so reads hit recent writes.
      for (int i = 0; i < 3000; i++) begin
         rv.chk = 1'b0;
         rv.rst = ($urandom_range(0, 99) == 0);
         rv.rd0 = ($urandom_range(0, 2) == 0);
         rv.wr0 = ($urandom_range(0, 3) == 0);
         rv.rd1 = ($urandom_range(0, 2) == 0);
         rv.wr1 = ($urandom_range(0, 3) == 0);
         rv.a0  = 10'($urandom_range(0, 15));
         rv.a1  = 10'($urandom_range(0, 15));
         rv.d0  = $urandom;
         rv.d1  = $urandom;
         rv.be0 = 4'($urandom_range(0, 15));
         rv.be1 = 4'($urandom_range(0, 15));
         rv.ew = '0; rv.erv = '0; rv.edata = '0;
         run_cycle(rv);
      end

      // Drain any in-flight reads.
      rv = mk(0, OP_IDLE, 0, 0, 0, OP_IDLE, 0, 0, 0, 2'b00, 2'b00, 0);
      rv.chk = 1'b0;
      repeat (3) run_cycle(rv);
      if (exp_q.size() != 0) check("pending_reads", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/qsys_data_arbiter.md
# qsys_data_arbiter

Two-requester arbiter that shares the single-port 1024x32 on-chip data RAM between two Avalon-MM masters. Each cycle it grants at most one read or write, registers the winning command into the RAM port, and routes read data back to the owner with fixed latency. It sits between the two Avalon-MM masters and the RAM's slave port inside the qsys subsystem.

## Interface
- `ADDR_W`, 10, word address width (1024 words)
- `DATA_W`, 32, data width; `BE_W = DATA_W/8` (4)
- `clk`  in  1  system clock; every register is clocked on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `mN_address`  in  ADDR_W  requester N word address (N = 0, 1)
- `mN_byteenable`  in  BE_W  requester N byte lanes
- `mN_read`  in  1  read request
- `mN_write`  in  1  write request
- `mN_writedata`  in  DATA_W  write data
- `mN_waitrequest`  out  1  command not accepted this cycle
- `mN_readdata`  out  DATA_W  read data, qualified by `mN_readdatavalid`
- `mN_readdatavalid`  out  1  one-cycle read-return strobe
- `ram_address`  out  ADDR_W  RAM address
- `ram_byteenable`  out  BE_W  RAM byte enables
- `ram_chipselect`  out  1  RAM select
- `ram_write`  out  1  RAM write
- `ram_writedata`  out  DATA_W  RAM write data
- `ram_clken`  out  1  RAM clock enable; tied to 1
- `ram_readdata`  in  DATA_W  RAM output (valid one cycle after address registration)

## Operation
- A request is active when `mN_read | mN_write`. If both are set, it is treated as a write and the read is ignored.
- Grant is combinational in cycle T:
  - Exactly one requester active: that requester is granted.
  - Both active: the requester not granted most recently wins.
- `mN_waitrequest = active_N & ~grant_N`.
- On grant, the command registers load address, byteenable, writedata, write and chipselect. The RAM sees them in cycle T+1, with `ram_chipselect` high for exactly one cycle per accepted command.
- `last_grant` updates only on an accepted command. Idle cycles leave it unchanged.
- Read-return pipeline:
  - Two stages carry {valid, id}.
  - For a read accepted in T, `mid_readdatavalid` pulses in T+2.
  - `mN_readdata` is driven continuously from `ram_readdata` for both requesters.
- Writes produce no response.
- Throughput is one command per cycle aggregate. Back-to-back grants to the same requester are allowed when the other is idle.
- Ordering: a write followed by a read to the same address returns the new data, because the RAM executes commands in grant order.

## Timing
- Reset values:
  - All `ram_*` outputs 0, except `ram_clken` = 1.
  - `mN_readdatavalid` 0.
  - `mN_waitrequest` 1 while `reset` is high.
  - `last_grant` = 1, so m0 wins the first tie.
- Read latency: fixed 2 cycles from acceptance (waitrequest low with read high) to readdatavalid.
- Reset mid-operation clears both return stages. In-flight reads are dropped and no `readdatavalid` is asserted after reset deasserts.
- Both requesters active every cycle: grants strictly alternate m0, m1, m0, …
- Requester drops its request while waiting: no grant, no state change.

## Configuration
- `QSYS_DATA_ARB_FIXED_PRIO_EN`
  - Defined: m0 always wins ties, `last_grant` is not implemented, and m1 may starve.
  - Undefined (default): round-robin as described.
  - Latency and reset behaviour are identical in both builds.

## Structure
- Package `qsys_data_arb_pkg`:
  - Constants `ADDR_W`, `DATA_W`, `BE_W`, `READ_LATENCY = 2`.
  - Typedef `req_id_t` (1 bit).
  - Struct `arb_cmd_t` {addr, be, wdata, write}.
- Sub-module `qsys_data_arb_rr`: 2-way grant logic with the `last_grant` register. The macro selects its fixed-priority variant.

## Test plan
- m0 writes 0xDEADBEEF to addr 0x005, be=0xF; then m0 reads 0x005 → m0_readdatavalid exactly 2 cycles after acceptance, data 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously (addr 0x010 / 0x020 preloaded 0x11111111 / 0x22222222) for 8 cycles → grants alternate starting with m0; returns alternate 0x11111111, 0x22222222.
- m1 writes 0xAABBCCDD, be=0x3, to a word holding 0 → subsequent read returns 0x0000CCDD.
- Same cycle: m0 writes 0x12345678 to 0x100 and m1 reads 0x100, m0 last granted → m1 granted first and reads the old value; m0's write lands next cycle.
- Reset asserted the cycle after a read acceptance → no readdatavalid on either port; `ram_chipselect` 0 and waitrequest 1 during reset.
- With `QSYS_DATA_ARB_FIXED_PRIO_EN`, both requesting for 4 cycles → m0 granted all 4, m1_waitrequest held high.
